// File: rtl/md_scheduler_if.sv
// Handshake/bus bundle between the E/D pipeline stages
// and the multiply/divide scheduler.
interface md_scheduler_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        D_is_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        md_stall;

  modport master (
    output start,
    output md_op,
    output rs_val,
    output rt_val,
    output D_is_md,
    input  hi,
    input  lo,
    input  busy,
    input  md_stall
  );

  modport slave (
    input  start,
    input  md_op,
    input  rs_val,
    input  rt_val,
    input  D_is_md,
    output hi,
    output lo,
    output busy,
    output md_stall
  );
endinterface

// File: rtl/md_scheduler.sv
// Multi-cycle multiply/divide sequencer; owns HI/LO
// and raises md_stall for D-stage md instructions.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic          clk,
  input logic          reset,
  md_scheduler_if.slave bus
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic [31:0]   hi_q;
  logic [31:0]   hi_n;
  logic [31:0]   lo_q;
  logic [31:0]   lo_n;
  logic [31:0]   a_q;
  logic [31:0]   a_n;
  logic [31:0]   b_q;
  logic [31:0]   b_n;
  logic [1:0]    op_q;
  logic [1:0]    op_n;

  logic is_md;
  logic is_mthi;
  logic is_mtlo;

  assign is_md   = ~bus.md_op[2];
  assign is_mthi = (bus.md_op == 3'd4);
  assign is_mtlo = (bus.md_op == 3'd5);

  // op_q[0] set means unsigned (multu/divu)
  logic        sgn;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] mq;
  logic [31:0] mr;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div_zero;

  assign sgn  = ~op_q[0];
  assign prod = {{32{sgn & a_q[31]}}, a_q} *
                {{32{sgn & b_q[31]}}, b_q};

  // Magnitude division keeps 0x80000000 / -1 well defined
  assign a_neg    = sgn & a_q[31];
  assign b_neg    = sgn & b_q[31];
  assign a_mag    = a_neg ? (32'd0 - a_q) : a_q;
  assign b_mag    = b_neg ? (32'd0 - b_q) : b_q;
  assign div_zero = (b_q == 32'd0);
  assign mq       = div_zero ? 32'd0 : (a_mag / b_mag);
  assign mr       = div_zero ? 32'd0 : (a_mag % b_mag);
  assign quo      = (a_neg ^ b_neg) ? (32'd0 - mq) : mq;
  assign rem      = a_neg ? (32'd0 - mr) : mr;

  always_comb begin
    state_n = state;
    count_n = count;
    hi_n    = hi_q;
    lo_n    = lo_q;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          unique case (1'b1)
            is_md: begin
              a_n     = bus.rs_val;
              b_n     = bus.rt_val;
              op_n    = bus.md_op[1:0];
              count_n = bus.md_op[1] ? CW'(DIV_CYCLES)
                                     : CW'(MULT_CYCLES);
              state_n = BUSY;
            end
            is_mthi: hi_n = bus.rs_val;
            is_mtlo: lo_n = bus.rs_val;
            default: ;
          endcase
        end
      end
      BUSY: begin
        count_n = count - 1'b1;
        if (count == CW'(1)) begin
          state_n = IDLE;
          if (!op_q[1]) begin
            {hi_n, lo_n} = prod;
          end else if (!div_zero) begin
            hi_n = rem;
            lo_n = quo;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      a_q   <= a_n;
      b_q   <= b_n;
      op_q  <= op_n;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = (state == BUSY);
  assign bus.md_stall = bus.D_is_md &
                        (bus.busy | (bus.start & is_md));

endmodule

// File: tb/tb_md_scheduler.sv
// Scoreboard bench for md_scheduler: stimulus queues
// expectations, a negedge monitor pops and compares.
module tb_md_scheduler;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  md_scheduler_if bus ();

  md_scheduler #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
  } probe_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } done_t;

  probe_t pq[$];
  string  pname[$];
  done_t  dq[$];
  string  dname[$];

  int   checks = 0;
  int   errors = 0;
  int   run_len = 0;
  logic busy_prev = 1'b0;
  logic rst_edge = 1'b0;
  logic done_req = 1'b0;
  logic finished = 1'b0;

  always @(posedge clk) rst_edge <= reset;

  task automatic check(input string n,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    probe_t p;
    done_t  d;
    string  n;
    if (bus.start && bus.busy) begin
      errors++;
      $display("FAIL start_while_busy: got 1 expected 0");
    end
    while (pq.size() != 0) begin
      p = pq.pop_front();
      n = pname.pop_front();
      check({n, ".hi"}, bus.hi, p.hi);
      check({n, ".lo"}, bus.lo, p.lo);
      check({n, ".busy"}, 32'(bus.busy), 32'(p.busy));
      check({n, ".stall"}, 32'(bus.md_stall), 32'(p.stall));
    end
    if (bus.busy) run_len++;
    if (busy_prev && !bus.busy) begin
      if (rst_edge) begin
        run_len = 0;
      end else if (dq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
        run_len = 0;
      end else begin
        d = dq.pop_front();
        n = dname.pop_front();
        check({n, ".hi"}, bus.hi, d.hi);
        check({n, ".lo"}, bus.lo, d.lo);
        check({n, ".cycles"}, 32'(run_len), 32'(d.cycles));
        run_len = 0;
      end
    end
    busy_prev = bus.busy;
    if (done_req && !finished) begin
      check("scoreboard_drained",
            32'(dq.size() + pq.size()), 32'd0);
      finished = 1'b1;
    end
  end

  task automatic drive(input logic s, input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.start  = s;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
  endtask

  task automatic probe(input string n,
                       input logic [31:0] h,
                       input logic [31:0] l,
                       input logic b, input logic s);
    pq.push_back('{hi: h, lo: l, busy: b, stall: s});
    pname.push_back(n);
    @(negedge clk);
  endtask

  task automatic run(input string n, input logic [2:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] eh,
                     input logic [31:0] el,
                     input int cyc);
    @(posedge clk); #1;
    dq.push_back('{hi: eh, lo: el, cycles: cyc});
    dname.push_back(n);
    drive(1'b1, op, a, b);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    for (int i = 0; i < 40 && dq.size() != 0; i++)
      @(posedge clk);
  endtask

  task automatic mt(input logic [2:0] op,
                    input logic [31:0] a);
    @(posedge clk); #1;
    drive(1'b1, op, a, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.D_is_md = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    probe("reset_idle", 32'h0, 32'h0, 1'b0, 1'b0);

    run("mult", 3'd0, 32'hFFFF_FFFE, 32'd3,
        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    run("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 32'h0000_0001, 5);
    run("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run("div_negdiv", 3'd2, 32'd7, 32'hFFFF_FFFE,
        32'h0000_0001, 32'hFFFF_FFFD, 10);
    run("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h0, 32'h8000_0000, 10);
    run("divu", 3'd3, 32'd100, 32'd7,
        32'd2, 32'd14, 10);

    mt(3'd4, 32'h11);
    mt(3'd5, 32'h22);
    @(posedge clk); #1;
    probe("mt_set", 32'h11, 32'h22, 1'b0, 1'b0);

    run("divu_zero", 3'd3, 32'd5, 32'd0,
        32'h11, 32'h22, 10);

    @(posedge clk); #1;
    bus.D_is_md = 1'b1;
    drive(1'b1, 3'd2, 32'd100, 32'd3);
    probe("abort_start", 32'h11, 32'h22, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      probe("abort_busy", 32'h11, 32'h22, 1'b1, 1'b1);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    probe("after_reset", 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 3'd4, 32'h1234, 32'd0);
    probe("mthi_nostall", 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    probe("mthi_hi", 32'h1234, 32'h0, 1'b0, 1'b0);
    bus.D_is_md = 1'b0;

    done_req = 1'b1;
    for (int i = 0; i < 10 && !finished; i++)
      @(posedge clk);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Sequences the multi-cycle multiply/divide unit and owns the HI/LO registers for the 5-stage MIPS pipeline.
- Accepts an operation launched from the E stage and runs it for a fixed latency, during which it holds busy.
- Commits the result to HI/LO on completion.
- Raises md_stall when the D-stage instruction needs the unit while it is occupied. The pipeline's stall controller ORs md_stall into its stall input.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >=1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >=1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  E-stage instruction is an md-unit op this cycle
- md_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved
- rs_val  in  32  forwarded rs operand from E
- rt_val  in  32  forwarded rt operand from E
- D_is_md  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  unit executing a mult/div
- md_stall  out  1  stall request to the stall controller

Behaviour:
- Reset: on a rising edge with reset=1, hi=0, lo=0, busy=0, internal count=0, state=IDLE. Reset overrides start and aborts any operation in flight with no HI/LO write.
- States: IDLE, BUSY.
- IDLE with start=1 and md_op in 0-3:
  - latch rs_val/rt_val/md_op.
  - load count with MULT_CYCLES (ops 0,1) or DIV_CYCLES (ops 2,3).
  - go to BUSY. busy=1 from the following cycle.
- IDLE with start=1 and md_op=4: hi<=rs_val at that edge; state stays IDLE, busy stays 0.
- IDLE with start=1 and md_op=5: lo<=rs_val at that edge; state stays IDLE, busy stays 0.
- IDLE with start=1 and md_op 6-7: no effect.
- BUSY: count decrements each edge.
  - On the edge where count==1: write the result to hi/lo, set busy=0, return to IDLE.
  - busy is therefore high for exactly N cycles after the start edge. New HI/LO values are visible in the first cycle after busy falls.
- start while BUSY is ignored. The pipeline must never issue it; the bench flags it as an error.
- Arithmetic, on the latched operands:
  - mult: {hi,lo} = signed 32x32 product, 64 bits.
  - multu: {hi,lo} = unsigned 32x32 product, 64 bits.
  - div: lo = signed quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - divu: lo = unsigned quotient; hi = unsigned remainder.
- Boundary cases:
  - Divide by zero (rt==0) for div or divu: the operation still occupies DIV_CYCLES, and hi/lo are left unchanged at completion.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- md_stall = D_is_md & (busy | (start & md_op<=3)). It is combinational and has no reset dependence beyond busy.
  - mthi/mtlo in E do not stall D.
  - md_stall in the last BUSY cycle is still 1. D advances the cycle after busy falls, so mfhi/mflo read the committed value.
- hi/lo are written only at completion, on mthi/mtlo, or at reset. They hold their value in every other cycle.

Test Plan:
- Reset, then idle for 3 cycles -> hi=0, lo=0, busy=0, md_stall=0.
- mult, rs=0xFFFFFFFE (-2), rt=3, single start pulse -> busy=1 for exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu, rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- div, rs=-7 (0xFFFFFFF9), rt=2 -> busy for 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu, rt=0, with hi=0x11, lo=0x22 beforehand -> busy for 10 cycles; hi=0x11, lo=0x22 unchanged.
- div start, then D_is_md=1 every cycle, then assert reset on the 4th busy cycle:
  - md_stall=1 in the start cycle and in each busy cycle until reset.
  - After the reset edge: busy=0, md_stall=0, hi=lo=0.
  - Then mthi rs=0x1234 with D_is_md=1 -> md_stall=0; hi=0x1234 on the next cycle with no busy.
